// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit for an N-way in-order superscalar pipeline.
// A per-register countdown scoreboard drives RAW/jr stalls, in-order lane
// suppression and flush control, plus a saturating stall-cycle counter.

// Per-lane hazard detection against the scoreboard and older lanes in the bundle.
module hazard_lane #(
    parameter int LANES = 2,
    parameter int REGW  = 5,
    parameter int LATW  = 2
) (
    input  logic [REGW-1:0]                    rs_i,
    input  logic [REGW-1:0]                    rt_i,
    input  logic                               rs_used_i,
    input  logic                               rt_used_i,
    input  logic                               jr_i,
    input  logic [LANES-1:0]                   older_wr_i,
    input  logic [LANES*REGW-1:0]              dst_all_i,
    input  logic [(2**REGW)-1:0][LATW-1:0]     fwd_tab_i,
    input  logic [(2**REGW)-1:0][LATW-1:0]     rdy_tab_i,
    output logic                               hazard_o
);
    // jr consumes rs in ID, so it checks the ready counter instead of forwarding
    always_comb begin
        hazard_o = 1'b0;
        if (rs_used_i && !jr_i && fwd_tab_i[rs_i] != '0) hazard_o = 1'b1;
        if (rt_used_i && fwd_tab_i[rt_i] != '0)          hazard_o = 1'b1;
        if (jr_i && rdy_tab_i[rs_i] != '0)               hazard_o = 1'b1;
        // no bypass between lanes of one bundle: any older writer of a source blocks
        for (int j = 0; j < LANES; j++) begin
            if (older_wr_i[j] && dst_all_i[j*REGW +: REGW] != '0 &&
                (((rs_used_i || jr_i) && rs_i == dst_all_i[j*REGW +: REGW]) ||
                 (rt_used_i && rt_i == dst_all_i[j*REGW +: REGW])))
                hazard_o = 1'b1;
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int LANES = 2,
    parameter int REGW  = 5,
    parameter int LATW  = 2,
    parameter int CNTW  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES-1:0]        valid_d,
    input  logic [LANES*REGW-1:0]   rs_d,
    input  logic [LANES*REGW-1:0]   rt_d,
    input  logic [LANES-1:0]        rs_used_d,
    input  logic [LANES-1:0]        rt_used_d,
    input  logic [LANES-1:0]        jr_d,
    input  logic [LANES-1:0]        wr_en_d,
    input  logic [LANES*REGW-1:0]   dst_d,
    input  logic [LANES*LATW-1:0]   fwd_lat_d,
    input  logic [LANES*LATW-1:0]   rdy_lat_d,
    input  logic                    pc_src,
    input  logic [LANES-1:0]        mispredict_e,
    output logic [LANES-1:0]        issue,
    output logic [LANES-1:0]        stall,
    output logic                    flush_ifid,
    output logic                    flush_ex,
    output logic [CNTW-1:0]         stall_cycles
);
    localparam int NREG = 2**REGW;

    logic [NREG-1:0][LATW-1:0] fwd_q, fwd_d;
    logic [NREG-1:0][LATW-1:0] rdy_q, rdy_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic [LANES-1:0]          hz;
    logic                      blk;

    function automatic logic [LATW-1:0] dec_sat(input logic [LATW-1:0] x);
        return (x != '0) ? x - LATW'(1) : '0;
    endfunction

    function automatic logic [LATW-1:0] max_lat(input logic [LATW-1:0] a, input logic [LATW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam logic [LANES-1:0] OLDER = LANES'((1 << i) - 1);
            logic [LANES-1:0] older_wr;
            assign older_wr = valid_d & wr_en_d & OLDER;
            hazard_lane #(.LANES(LANES), .REGW(REGW), .LATW(LATW)) u_lane (
                .rs_i       (rs_d[i*REGW +: REGW]),
                .rt_i       (rt_d[i*REGW +: REGW]),
                .rs_used_i  (rs_used_d[i]),
                .rt_used_i  (rt_used_d[i]),
                .jr_i       (jr_d[i]),
                .older_wr_i (older_wr),
                .dst_all_i  (dst_d),
                .fwd_tab_i  (fwd_q),
                .rdy_tab_i  (rdy_q),
                .hazard_o   (hz[i])
            );
        end
    endgenerate

    assign flush_ex   = (mispredict_e != '0);
    assign flush_ifid = pc_src | flush_ex;

    // a hazard on any valid older-or-equal lane holds this lane; flush wins over stall
    always_comb begin
        blk   = 1'b0;
        stall = '0;
        for (int i = 0; i < LANES; i++) begin
            blk      = blk | (valid_d[i] & hz[i]);
            stall[i] = valid_d[i] & blk & ~flush_ifid;
        end
    end

    assign issue = valid_d & ~stall & {LANES{~flush_ifid}};

    // decrement every counter, then allocate for issuing writers (youngest lane last, so it wins)
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            fwd_d[r] = dec_sat(fwd_q[r]);
            rdy_d[r] = dec_sat(rdy_q[r]);
        end
        for (int i = 0; i < LANES; i++) begin
            if (issue[i] && wr_en_d[i] && dst_d[i*REGW +: REGW] != '0) begin
                fwd_d[dst_d[i*REGW +: REGW]] = max_lat(fwd_lat_d[i*LATW +: LATW],
                                                       dec_sat(fwd_q[dst_d[i*REGW +: REGW]]));
                rdy_d[dst_d[i*REGW +: REGW]] = max_lat(rdy_lat_d[i*LATW +: LATW],
                                                       dec_sat(rdy_q[dst_d[i*REGW +: REGW]]));
            end
        end
    end

    // saturating count of cycles in which some valid lane was held
    always_comb begin
        cnt_d = cnt_q;
        if ((stall & valid_d) != '0 && cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
    end

    // scoreboard and counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_q <= '0;
            rdy_q <= '0;
            cnt_q <= '0;
        end else begin
            fwd_q <= fwd_d;
            rdy_q <= rdy_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a 2-lane and a 4-lane instance.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // 2-lane instance
    logic [1:0]  va, rsua, rtua, jra, wra, mpa, isa, sta;
    logic [9:0]  rsa, rta, dsta;
    logic [3:0]  fla, rla;
    logic        pca, fia, fea;
    logic [31:0] sca;

    hazard_scoreboard #(.LANES(2)) dut_a (
        .clk(clk), .reset(reset), .valid_d(va), .rs_d(rsa), .rt_d(rta),
        .rs_used_d(rsua), .rt_used_d(rtua), .jr_d(jra), .wr_en_d(wra), .dst_d(dsta),
        .fwd_lat_d(fla), .rdy_lat_d(rla), .pc_src(pca), .mispredict_e(mpa),
        .issue(isa), .stall(sta), .flush_ifid(fia), .flush_ex(fea), .stall_cycles(sca)
    );

    // 4-lane instance
    logic [3:0]  vb, rsub, rtub, jrb, wrb, mpb, isb, stb;
    logic [19:0] rsb, rtb, dstb;
    logic [7:0]  flb, rlb;
    logic        pcb, fib, feb;
    logic [31:0] scb;

    hazard_scoreboard #(.LANES(4)) dut_b (
        .clk(clk), .reset(reset), .valid_d(vb), .rs_d(rsb), .rt_d(rtb),
        .rs_used_d(rsub), .rt_used_d(rtub), .jr_d(jrb), .wr_en_d(wrb), .dst_d(dstb),
        .fwd_lat_d(flb), .rdy_lat_d(rlb), .pc_src(pcb), .mispredict_e(mpb),
        .issue(isb), .stall(stb), .flush_ifid(fib), .flush_ex(feb), .stall_cycles(scb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        va = '0; rsa = '0; rta = '0; rsua = '0; rtua = '0; jra = '0; wra = '0;
        dsta = '0; fla = '0; rla = '0; pca = 1'b0; mpa = '0;
        vb = '0; rsb = '0; rtb = '0; rsub = '0; rtub = '0; jrb = '0; wrb = '0;
        dstb = '0; flb = '0; rlb = '0; pcb = 1'b0; mpb = '0;
    endtask

    // lane fields: rs, rt, rs_used, rt_used, jr, wr_en, dst, fwd_lat, rdy_lat
    task automatic lane_a(input int l, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ru, input logic tu, input logic j, input logic w,
                          input logic [4:0] d, input logic [1:0] f, input logic [1:0] r);
        va[l] = 1'b1; rsa[l*5 +: 5] = rs; rta[l*5 +: 5] = rt; rsua[l] = ru; rtua[l] = tu;
        jra[l] = j; wra[l] = w; dsta[l*5 +: 5] = d; fla[l*2 +: 2] = f; rla[l*2 +: 2] = r;
    endtask

    task automatic lane_b(input int l, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ru, input logic tu, input logic j, input logic w,
                          input logic [4:0] d, input logic [1:0] f, input logic [1:0] r);
        vb[l] = 1'b1; rsb[l*5 +: 5] = rs; rtb[l*5 +: 5] = rt; rsub[l] = ru; rtub[l] = tu;
        jrb[l] = j; wrb[l] = w; dstb[l*5 +: 5] = d; flb[l*2 +: 2] = f; rlb[l*2 +: 2] = r;
    endtask

    // advance to just after the next rising edge with idle inputs
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle();
        #12;
        chk("reset_issue", 32'(isa), 0);
        chk("reset_stall", 32'(sta), 0);
        chk("reset_flush", {30'b0, fia, fea}, 0);
        chk("reset_cnt", sca, 0);
        cyc();
        reset = 1'b0;
        cyc();

        // load-use: lw $3 then add $4,$3,$1
        lane_a(0, 5'd1, 5'd0, 1, 0, 0, 1, 5'd3, 2'd1, 2'd2); settle();
        chk("lu_issue_t", 32'(isa), 32'b01);
        cyc(); lane_a(0, 5'd3, 5'd1, 1, 1, 0, 1, 5'd4, 2'd0, 2'd2); settle();
        chk("lu_stall_t1", 32'(sta), 32'b01);
        chk("lu_issue_t1", 32'(isa), 32'b00);
        cyc(); lane_a(0, 5'd3, 5'd1, 1, 1, 0, 1, 5'd4, 2'd0, 2'd2); settle();
        chk("lu_issue_t2", 32'(isa), 32'b01);
        chk("lu_cnt", sca, 1);
        cyc(); cyc(); cyc();

        // intra-bundle: add $5 ; sub $6,$5,$2
        lane_a(0, 5'd1, 5'd2, 1, 1, 0, 1, 5'd5, 2'd0, 2'd2);
        lane_a(1, 5'd5, 5'd2, 1, 1, 0, 1, 5'd6, 2'd0, 2'd2); settle();
        chk("ib_issue", 32'(isa), 32'b01);
        chk("ib_stall", 32'(sta), 32'b10);
        cyc(); lane_a(1, 5'd5, 5'd2, 1, 1, 0, 1, 5'd6, 2'd0, 2'd2); settle();
        chk("ib_issue_next", 32'(isa), 32'b10);
        chk("ib_cnt", sca, 2);
        cyc(); cyc(); cyc();

        // jr after ALU producer: two bubbles
        lane_a(0, 5'd1, 5'd2, 1, 1, 0, 1, 5'd31, 2'd0, 2'd2); settle();
        chk("jr_prod_issue", 32'(isa), 32'b01);
        cyc(); lane_a(0, 5'd31, 5'd0, 1, 0, 1, 0, 5'd0, 2'd0, 2'd0); settle();
        chk("jr_stall_t1", 32'(sta), 32'b01);
        cyc(); lane_a(0, 5'd31, 5'd0, 1, 0, 1, 0, 5'd0, 2'd0, 2'd0); settle();
        chk("jr_stall_t2", 32'(sta), 32'b01);
        cyc(); lane_a(0, 5'd31, 5'd0, 1, 0, 1, 0, 5'd0, 2'd0, 2'd0); settle();
        chk("jr_issue_t3", 32'(isa), 32'b01);
        chk("jr_cnt", sca, 4);
        cyc(); cyc(); cyc();
        // same producer, non-jr reader goes straight through
        lane_a(0, 5'd1, 5'd2, 1, 1, 0, 1, 5'd31, 2'd0, 2'd2); settle();
        cyc(); lane_a(0, 5'd31, 5'd1, 1, 1, 0, 1, 5'd8, 2'd0, 2'd2); settle();
        chk("nonjr_issue", 32'(isa), 32'b01);
        chk("nonjr_stall", 32'(sta), 32'b00);
        cyc(); cyc(); cyc();

        // flush beats stall and blocks allocation
        lane_a(0, 5'd1, 5'd0, 1, 0, 0, 1, 5'd9, 2'd1, 2'd2); settle();
        cyc(); lane_a(0, 5'd9, 5'd1, 1, 1, 0, 1, 5'd10, 2'd1, 2'd2); mpa = 2'b10; settle();
        chk("fl_flags", {30'b0, fia, fea}, 32'b11);
        chk("fl_stall", 32'(sta), 32'b00);
        chk("fl_issue", 32'(isa), 32'b00);
        cyc(); lane_a(0, 5'd10, 5'd9, 1, 1, 0, 0, 5'd0, 2'd0, 2'd0); settle();
        chk("fl_noalloc", 32'(isa), 32'b01);
        cyc(); lane_a(0, 5'd1, 5'd2, 1, 1, 0, 1, 5'd11, 2'd0, 2'd0); pca = 1'b1; settle();
        chk("pc_flags", {30'b0, fia, fea}, 32'b10);
        chk("pc_issue", 32'(isa), 32'b00);
        chk("fl_cnt", sca, 4);
        cyc(); cyc(); cyc();

        // WAW in one bundle: youngest lane's latency wins
        lane_a(0, 5'd1, 5'd2, 1, 1, 0, 1, 5'd7, 2'd0, 2'd2);
        lane_a(1, 5'd1, 5'd0, 1, 0, 0, 1, 5'd7, 2'd1, 2'd2); settle();
        chk("waw_issue", 32'(isa), 32'b11);
        cyc(); lane_a(0, 5'd7, 5'd0, 1, 0, 0, 1, 5'd12, 2'd0, 2'd0); settle();
        chk("waw_stall", 32'(sta), 32'b01);
        cyc(); lane_a(0, 5'd7, 5'd0, 1, 0, 0, 1, 5'd12, 2'd0, 2'd0); settle();
        chk("waw_issue2", 32'(isa), 32'b01);
        chk("waw_cnt", sca, 5);
        cyc(); cyc(); cyc();

        // register 0 is never tracked
        lane_a(0, 5'd1, 5'd0, 1, 0, 0, 1, 5'd0, 2'd3, 2'd3);
        lane_a(1, 5'd0, 5'd0, 1, 1, 0, 1, 5'd13, 2'd0, 2'd0); settle();
        chk("r0_intra", 32'(isa), 32'b11);
        cyc(); lane_a(0, 5'd0, 5'd0, 1, 0, 1, 0, 5'd0, 2'd0, 2'd0); settle();
        chk("r0_jr", 32'(isa), 32'b01);
        cyc(); cyc(); cyc();

        // 4 lanes: load-use on lane 3 with an independent older lane
        lane_b(3, 5'd1, 5'd0, 1, 0, 0, 1, 5'd3, 2'd1, 2'd2); settle();
        chk("b_lu_issue_t", 32'(isb), 32'b1000);
        cyc();
        lane_b(1, 5'd1, 5'd2, 1, 1, 0, 1, 5'd6, 2'd0, 2'd0);
        lane_b(3, 5'd3, 5'd1, 1, 1, 0, 1, 5'd4, 2'd0, 2'd2); settle();
        chk("b_lu_issue_t1", 32'(isb), 32'b0010);
        chk("b_lu_stall_t1", 32'(stb), 32'b1000);
        cyc(); lane_b(3, 5'd3, 5'd1, 1, 1, 0, 1, 5'd4, 2'd0, 2'd2); settle();
        chk("b_lu_issue_t2", 32'(isb), 32'b1000);
        chk("b_lu_cnt", scb, 1);
        cyc(); cyc(); cyc();
        // stalled lane 0 holds every younger lane
        lane_b(0, 5'd1, 5'd0, 1, 0, 0, 1, 5'd9, 2'd1, 2'd2); settle();
        cyc();
        lane_b(0, 5'd9, 5'd0, 1, 0, 0, 1, 5'd14, 2'd0, 2'd0);
        for (int l = 1; l < 4; l++) lane_b(l, 5'd1, 5'd2, 1, 1, 0, 1, 5'(20 + l), 2'd0, 2'd0);
        settle();
        chk("b_hold_stall", 32'(stb), 32'b1111);
        chk("b_hold_issue", 32'(isb), 32'b0000);
        cyc(); cyc(); cyc();

        // reset during a stall clears counters immediately
        lane_a(0, 5'd1, 5'd0, 1, 0, 0, 1, 5'd3, 2'd3, 2'd3); settle();
        cyc(); lane_a(0, 5'd3, 5'd0, 1, 0, 0, 1, 5'd4, 2'd0, 2'd0); settle();
        chk("rst_pre_stall", 32'(sta), 32'b01);
        reset = 1'b1; #1;
        chk("rst_stall_during", 32'(sta), 32'b00);
        chk("rst_cnt_during", sca, 0);
        chk("rst_cnt_b", scb, 0);
        @(posedge clk); #1;
        reset = 1'b0; settle();
        chk("rst_stall_after", 32'(sta), 32'b00);
        chk("rst_issue_after", 32'(isa), 32'b01);
        cyc(); settle();
        chk("rst_cnt_after", sca, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
